// File: rtl/systolic_array.sv
// ---------------------------------------------------------------------------
// systolic_array
//   DIM x DIM output-stationary multiply-accumulate array. A operands enter
//   on the left edge and shift right one PE per enabled cycle. B operands
//   enter on the top edge and shift down the same way. Every PE adds the
//   product of the operands passing through it into its local C register.
//   The per-row/per-column skew delay FIFOs sit upstream of this block, so
//   A and B arrive here already skewed.
//
//   Optional build macro:
//     SYSTOLIC_SATURATE_EN - clamp product and running sum to the signed
//                            BITS_C range instead of wrapping.
//
// Ports
//   clk   : clock
//   rst_n : synchronous active-low reset, clears all PE registers
//   en    : shift operands and accumulate
//   WrEn  : load Cin into the C registers of row Crow
//   A     : A[i] enters PE(i,0)
//   B     : B[j] enters PE(0,j)
//   Crow  : row select for WrEn and Cout
//   Cin   : Cin[j] is written to C(Crow,j)
//   Cout  : Cout[j] = C(Crow,j), combinational; zero for Crow >= DIM
// ---------------------------------------------------------------------------
module systolic_array #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        WrEn,
    input  logic [DIM-1:0][BITS_AB-1:0] A,
    input  logic [DIM-1:0][BITS_AB-1:0] B,
    input  logic [$clog2(DIM)-1:0]      Crow,
    input  logic [DIM-1:0][BITS_C-1:0]  Cin,
    output logic [DIM-1:0][BITS_C-1:0]  Cout
);

`ifdef SYSTOLIC_SATURATE_EN
    // Wide enough to hold the full product or a BITS_C + BITS_C sum.
    localparam int W = ((2*BITS_AB > BITS_C) ? 2*BITS_AB : BITS_C) + 1;
    localparam logic signed [W-1:0] C_MAX = {{(W-BITS_C+1){1'b0}}, {(BITS_C-1){1'b1}}};
    localparam logic signed [W-1:0] C_MIN = ~C_MAX;

    function automatic logic signed [BITS_C-1:0] clamp_c(input logic signed [W-1:0] x);
        if (x > C_MAX)
            return C_MAX[BITS_C-1:0];
        else if (x < C_MIN)
            return C_MIN[BITS_C-1:0];
        else
            return x[BITS_C-1:0];
    endfunction
`endif

    logic signed [BITS_AB-1:0] r_a    [DIM][DIM];
    logic signed [BITS_AB-1:0] r_b    [DIM][DIM];
    logic signed [BITS_C-1:0]  r_c    [DIM][DIM];
    logic signed [BITS_AB-1:0] w_a_in [DIM][DIM];
    logic signed [BITS_AB-1:0] w_b_in [DIM][DIM];
    logic signed [BITS_C-1:0]  w_acc  [DIM][DIM];
    logic                      w_wr_row [DIM];

    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
        // An out-of-range Crow matches no row, so the write is dropped.
        assign w_wr_row[gi] = WrEn && (32'(Crow) == gi);

        for (genvar gj = 0; gj < DIM; gj++) begin : g_col
            logic signed [2*BITS_AB-1:0] w_prod;

            if (gj == 0) begin : g_a_edge
                assign w_a_in[gi][gj] = A[gi];
            end else begin : g_a_int
                assign w_a_in[gi][gj] = r_a[gi][gj-1];
            end

            if (gi == 0) begin : g_b_edge
                assign w_b_in[gi][gj] = B[gj];
            end else begin : g_b_int
                assign w_b_in[gi][gj] = r_b[gi-1][gj];
            end

            assign w_prod = w_a_in[gi][gj] * w_b_in[gi][gj];

`ifdef SYSTOLIC_SATURATE_EN
            logic signed [BITS_C-1:0] w_prod_c;
            assign w_prod_c       = clamp_c(W'(w_prod));
            assign w_acc[gi][gj]  = clamp_c(W'(r_c[gi][gj]) + W'(w_prod_c));
`else
            assign w_acc[gi][gj]  = r_c[gi][gj] + BITS_C'(w_prod);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    r_a[i][j] <= '0;
                    r_b[i][j] <= '0;
                    r_c[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    if (en) begin
                        r_a[i][j] <= w_a_in[i][j];
                        r_b[i][j] <= w_b_in[i][j];
                    end
                    // A load wins over accumulation in the selected row only;
                    // operands keep shifting through it.
                    if (w_wr_row[i])
                        r_c[i][j] <= signed'(Cin[j]);
                    else if (en)
                        r_c[i][j] <= w_acc[i][j];
                end
            end
        end
    end

    always_comb begin
        Cout = '0;
        for (int i = 0; i < DIM; i++) begin
            if (32'(Crow) == i) begin
                for (int j = 0; j < DIM; j++)
                    Cout[j] = r_c[i][j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
module tb_systolic_array;
    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int DIM     = 8;
    localparam int NCYC    = 3*DIM - 2;
    localparam int ROWW    = DIM*BITS_C;

    logic                        clk;
    logic                        rst_n;
    logic                        en;
    logic                        WrEn;
    logic [DIM-1:0][BITS_AB-1:0] A;
    logic [DIM-1:0][BITS_AB-1:0] B;
    logic [$clog2(DIM)-1:0]      Crow;
    logic [DIM-1:0][BITS_C-1:0]  Cin;
    logic [DIM-1:0][BITS_C-1:0]  Cout;

    int n_cmp = 0;
    int n_bad = 0;

    int ma [DIM][DIM];
    int mb [DIM][DIM];

    systolic_array #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .WrEn (WrEn),
        .A    (A),
        .B    (B),
        .Crow (Crow),
        .Cin  (Cin),
        .Cout (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [ROWW-1:0] got, input logic [ROWW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: fit a value into the signed BITS_C range.
    function automatic int fit_c(input int x);
        int lo, hi, m;
        lo = -(1 << (BITS_C-1));
        hi = (1 << (BITS_C-1)) - 1;
`ifdef SYSTOLIC_SATURATE_EN
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
`else
        m = x & ((1 << BITS_C) - 1);
        if (m > hi) m = m - (1 << BITS_C);
        return m;
`endif
    endfunction

    function automatic int mac(input int c, input int p);
        return fit_c(c + fit_c(p));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en   = 1'b0;
        WrEn = 1'b0;
        A    = '0;
        B    = '0;
        Cin  = '0;
        Crow = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        WrEn  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DIM; i++) begin
                A[i]   = BITS_AB'($urandom);
                B[i]   = BITS_AB'($urandom);
                Cin[i] = BITS_C'($urandom);
            end
            Crow = ($clog2(DIM))'($urandom);
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    // Streams ma x mb with external skew; optional random en-low gaps.
    task automatic run_mm(input bit gaps);
        int v;
        for (int t = 0; t < NCYC; t++) begin
            for (int i = 0; i < DIM; i++) begin
                v = (t-i >= 0 && t-i < DIM) ? ma[i][t-i] : 0;
                A[i] = BITS_AB'(v);
                v = (t-i >= 0 && t-i < DIM) ? mb[t-i][i] : 0;
                B[i] = BITS_AB'(v);
            end
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    en = 1'b0;
                    tick();
                end
            end
            en = 1'b1;
            tick();
        end
        idle_inputs();
    endtask

    task automatic check_mm(input string tag);
        logic [DIM-1:0][BITS_C-1:0] er;
        int c;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                c = 0;
                for (int k = 0; k < DIM; k++)
                    c = mac(c, ma[i][k] * mb[k][j]);
                er[j] = BITS_C'(c);
            end
            Crow = ($clog2(DIM))'(i);
            #1;
            check_val($sformatf("%s_row%0d", tag, i), Cout, er);
        end
        Crow = '0;
    endtask

    task automatic load_identity();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = i*DIM + j;
            end
    endtask

    initial begin
        logic [DIM-1:0][BITS_C-1:0] er;
        logic [ROWW-1:0] exp_c00;

        rst_n = 1'b0;
        idle_inputs();

        // Reset clears every row even with en/WrEn active.
        do_reset();
        for (int i = 0; i < DIM; i++) begin
            Crow = ($clog2(DIM))'(i);
            #1;
            check_val($sformatf("reset_row%0d", i), Cout, '0);
        end

        // Identity x B returns B.
        load_identity();
        run_mm(1'b0);
        check_mm("ident");
        for (int j = 0; j < DIM; j++) er[j] = BITS_C'(3*DIM + j);
        Crow = 3'd3;
        #1;
        check_val("ident_row3_const", Cout, er);

        // Signed product: -3 * 5 summed DIM times.
        do_reset();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = -3;
                mb[i][j] = 5;
            end
        run_mm(1'b0);
        check_mm("signed");
        Crow = 3'd7;
        #1;
        check_val("signed_const", Cout, {DIM{16'hFF88}});

        // Identity again with random en gaps.
        do_reset();
        load_identity();
        run_mm(1'b1);
        check_mm("ident_gaps");

        // Random matrices, some with gaps.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    ma[i][j] = int'($urandom_range(0, 255)) - 128;
                    mb[i][j] = int'($urandom_range(0, 255)) - 128;
                end
            run_mm(r[0]);
            check_mm($sformatf("rand%0d", r));
        end

        // Preload with priority over accumulation in the same cycle.
        do_reset();
        for (int i = 0; i < DIM; i++) begin
            A[i]   = 8'd1;
            B[i]   = 8'd1;
            Cin[i] = 16'd100;
        end
        en   = 1'b1;
        WrEn = 1'b1;
        Crow = 3'd2;
        tick();
        WrEn = 1'b0;
        A    = '0;
        B    = '0;
        Cin  = '0;
        check_val("preload_row2", Cout, {DIM{16'd100}});
        Crow = 3'd0;
        #1;
        er = '0;
        er[0] = 16'd1;
        check_val("prio_row0", Cout, er);
        // B[0]=4 needs two hops to reach row 2; meet it with A[2]=4 there.
        B[0] = 8'd4;
        tick();
        B[0] = 8'd0;
        tick();
        A[2] = 8'd4;
        tick();
        A[2] = 8'd0;
        en   = 1'b0;
        Crow = 3'd2;
        #1;
        check_val("acc_c20", ROWW'(Cout[0]), ROWW'(16'd116));

        // Overflow on a single accumulation.
        do_reset();
        Cin[0] = 16'd32760;
        WrEn   = 1'b1;
        Crow   = 3'd0;
        tick();
        WrEn = 1'b0;
        Cin  = '0;
        A[0] = 8'd10;
        B[0] = 8'd10;
        en   = 1'b1;
        tick();
        en = 1'b0;
        A  = '0;
        B  = '0;
`ifdef SYSTOLIC_SATURATE_EN
        exp_c00 = ROWW'(16'h7FFF);
`else
        exp_c00 = ROWW'(16'h805C);
`endif
        check_val("ovf_c00", ROWW'(Cout[0]), exp_c00);

        // en low: random operands must not disturb C.
        for (int i = 0; i < DIM; i++) begin
            A[i] = BITS_AB'($urandom);
            B[i] = BITS_AB'($urandom);
        end
        tick();
        tick();
        check_val("hold_c00", ROWW'(Cout[0]), exp_c00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/systolic_array.md
# systolic_array

DIM×DIM output-stationary multiply-accumulate array fed by the per-row and per-column skew delay FIFOs. Row i's FIFO delays its A stream by i cycles, and column j's FIFO delays its B stream by j cycles. A operands enter on the left edge and propagate right. B operands enter on the top edge and propagate down. Each processing element (PE) accumulates the product of its operands into its local C register. C is loaded and read back one row at a time for preload and drain.

## Interface
- BITS_AB, 8, signed width of A/B operands
- BITS_C, 16, signed width of accumulators and C ports
- DIM, 8, array dimension (rows = columns)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  advance operand pipeline and accumulate
- WrEn  in  1  load Cin into C registers of row Crow
- A  in  [DIM-1:0][BITS_AB-1:0]  A[i] enters PE(i,0)
- B  in  [DIM-1:0][BITS_AB-1:0]  B[j] enters PE(0,j)
- Crow  in  $clog2(DIM)  row select for WrEn and Cout
- Cin  in  [DIM-1:0][BITS_C-1:0]  Cin[j] is written to C(Crow,j)
- Cout  out  [DIM-1:0][BITS_C-1:0]  Cout[j] = C(Crow,j)

## Operation
- Each PE(i,j) holds three registers: a_reg [BITS_AB], b_reg [BITS_AB] and c_reg [BITS_C].
- PE inputs:
  - a_in = A[i] when j==0, else a_reg of PE(i,j-1).
  - b_in = B[j] when i==0, else b_reg of PE(i-1,j).
- On a clock edge with en=1:
  - a_reg <= a_in
  - b_reg <= b_in
  - c_reg <= c_reg + a_in*b_in
- Arithmetic:
  - The product is signed BITS_AB×BITS_AB, giving a full 2*BITS_AB result.
  - The product is sign-extended or truncated to BITS_C before the add.
  - The sum wraps modulo 2^BITS_C (see Configuration).
- On a clock edge with en=0, all a_reg, b_reg and c_reg registers hold their values.
- WrEn=1 with a valid Crow: c_reg of every PE in row Crow <= Cin[j] at the clock edge.
- Priority when WrEn and en are both 1:
  - In row Crow, WrEn overrides accumulation.
  - a_reg/b_reg still shift in all rows.
  - All other rows accumulate normally.
- Cout is combinational from c_reg of row Crow and carries no added latency.
- Crow ≥ DIM (non-power-of-two DIM): WrEn is ignored and Cout is all zeros.
- Reset (rst_n=0 at the edge) clears every a_reg, b_reg and c_reg to 0, overriding en and WrEn. Reset mid-computation discards partial sums.

## Timing
- Reset values: all registers are 0, so Cout = 0 for any Crow.
- Operand propagation: one en cycle per PE hop. A[i] reaches PE(i,j) j en-cycles after entering. B behaves the same along columns.
- With upstream skew, A[i][k] and B[k][j] meet at PE(i,j) on en-cycle k+i+j (cycle 0 is the first en edge).
- A full DIM-deep product completes after 3*DIM-2 en cycles (22 for DIM=8). C is valid on Cout from the following cycle.
- Zero operands must be driven after the final k; stray non-zero operands corrupt downstream PEs.
- A C write becomes visible on Cout the cycle after the WrEn edge. Cout reflects a Crow change immediately.

## Configuration
- SYSTOLIC_SATURATE_EN, when defined:
  - Each accumulation clamps to the BITS_C signed range, [-2^(BITS_C-1), 2^(BITS_C-1)-1], on overflow.
  - The product itself is first clamped to the BITS_C signed range if it does not fit.
- When undefined, plain two's-complement wrap applies.
- WrEn loads are never clamped.

## Test plan
- Reset: drive random A/B with en=1 and WrEn=1, holding rst_n=0 for 3 cycles -> Cout=0 for every Crow 0..DIM-1.
- Identity × matrix: set A=I, set B[k][j]=k*DIM+j, skew externally, run 22 en cycles -> row i of Cout equals row i of B.
- Signed product: A all -3, B all 5, DIM=8, streamed skewed -> every C(i,j) = -120.
- en gaps: repeat the identity test with en deasserted on random cycles -> same result; registers hold during gaps.
- Preload plus priority: WrEn with Crow=2, Cin[j]=100, en=1, A=B=1 in the same cycle -> row 2 C=100 and row 0 C(0,0)=1. A subsequent accumulation of 4×4 into row 2 gives 116 at PE(2,0) once the operands arrive.
- Overflow, BITS_C=16: preload C(0,0)=32760, then feed A=B=10 once -> 32767 with SYSTOLIC_SATURATE_EN defined; -32676 without it.
